// File: rtl/tile_sequencer.sv
// Grants control to one tile at a time; advances on passfwd, retreats on passbak, ends in DONE/FAIL.
// myturn is Moore-decoded in GRANT; pulse at t gives the next grant at t+1; hold stalls the grant.
module tile_sequencer #(
    parameter int NUM_TILES = 81,
    parameter int IDX_W     = $clog2(NUM_TILES),
    parameter int BTCNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hold,
    input  logic [NUM_TILES-1:0] passfwd,
    input  logic [NUM_TILES-1:0] passbak,
    output logic [NUM_TILES-1:0] myturn,
    output logic [IDX_W-1:0]     cur_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 failed,
    output logic                 proto_err,
    output logic [BTCNT_W-1:0]   backtracks
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        GRANT = 5'b00010,
        WAIT  = 5'b00100,
        DONE  = 5'b01000,
        FAIL  = 5'b10000
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

    state_t state;
    logic   cur_fwd;
    logic   cur_bak;

    // Only the tile that owns control is listened to.
    assign cur_fwd = passfwd[cur_idx];
    assign cur_bak = passbak[cur_idx];

    assign myturn = (state == GRANT && !hold) ? (NUM_TILES'(1) << cur_idx) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cur_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            failed     <= 1'b0;
            proto_err  <= 1'b0;
            backtracks <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= GRANT;
                        cur_idx    <= '0;
                        backtracks <= '0;
                        busy       <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!hold) state <= WAIT;
                end
                WAIT: begin
                    // A simultaneous fwd+bak is a tile bug; backing off is the safe reading.
                    if (cur_bak) begin
                        if (cur_fwd) proto_err <= 1'b1;
                        if (backtracks != '1) backtracks <= backtracks + 1'b1;
                        if (cur_idx == '0) begin
                            state  <= FAIL;
                            failed <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            cur_idx <= cur_idx - 1'b1;
                            state   <= GRANT;
                        end
                    end else if (cur_fwd) begin
                        if (cur_idx == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cur_idx <= cur_idx + 1'b1;
                            state   <= GRANT;
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer (4 tiles, 2-bit backtrack counter) against a traversal-level model.
module tb_tile_sequencer;

    localparam int N      = 4;
    localparam int IDXW   = 2;
    localparam int BTW    = 2;
    localparam int BT_MAX = 3;

    logic            clock;
    logic            reset;
    logic            start;
    logic            hold;
    logic [N-1:0]    passfwd;
    logic [N-1:0]    passbak;
    logic [N-1:0]    myturn;
    logic [IDXW-1:0] cur_idx;
    logic            busy;
    logic            done;
    logic            failed;
    logic            proto_err;
    logic [BTW-1:0]  backtracks;

    int checks = 0;
    int errors = 0;

    // Response codes: 0 = passfwd, 1 = passbak, 2 = both at once.
    int script[$];
    int obs_order[$];
    int obs_extra;
    int obs_late;
    int exp_order[$];
    int exp_done, exp_failed, exp_bt, exp_proto, exp_idx;
    bit noise_en, hold_en;

    tile_sequencer #(.NUM_TILES(N), .IDX_W(IDXW), .BTCNT_W(BTW)) dut (
        .clock(clock), .reset(reset), .start(start), .hold(hold),
        .passfwd(passfwd), .passbak(passbak), .myturn(myturn), .cur_idx(cur_idx),
        .busy(busy), .done(done), .failed(failed), .proto_err(proto_err),
        .backtracks(backtracks)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; hold = 1'b0; passfwd = '0; passbak = '0;
        noise_en = 1'b0; hold_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reference: walk the grid from the response list, independent of cycle timing.
    task automatic model_run();
        int idx;
        idx = 0;
        exp_order.delete();
        exp_done = 0; exp_failed = 0; exp_bt = 0; exp_proto = 0;
        foreach (script[k]) begin
            if (exp_done != 0 || exp_failed != 0) break;
            exp_order.push_back(idx);
            if (script[k] == 0) begin
                if (idx == N - 1) exp_done = 1; else idx++;
            end else begin
                if (script[k] == 2) exp_proto = 1;
                if (exp_bt < BT_MAX) exp_bt++;
                if (idx == 0) exp_failed = 1; else idx--;
            end
        end
        exp_idx = idx;
    endtask

    function automatic int order_diff();
        if (obs_order.size() != exp_order.size()) return 999;
        foreach (exp_order[k]) if (obs_order[k] != exp_order[k]) return k;
        return -1;
    endfunction

    task automatic drive_noise(input int idx);
        if (noise_en) begin
            passfwd = N'($urandom) & ~(N'(1) << idx);
            passbak = N'($urandom) & ~(N'(1) << idx);
        end else begin
            passfwd = '0;
            passbak = '0;
        end
    endtask

    // Returns the granted tile, -1 on timeout, -2 if myturn is not one-hot.
    task automatic wait_grant(output int idx);
        idx = -1;
        for (int i = 0; i < 60; i++) begin
            hold = (hold_en && i < 4) ? 1'($urandom_range(1, 0)) : 1'b0;
            #1;
            if (myturn != '0) begin
                if (i > 0) obs_late++;
                idx = -2;
                for (int b = 0; b < N; b++) if (myturn == (N'(1) << b)) idx = b;
                return;
            end
            tick();
        end
    endtask

    task automatic run_script(input int dmin, input int dmax);
        int idx, d;
        obs_order.delete();
        obs_extra = 0;
        obs_late  = 0;
        foreach (script[k]) begin
            wait_grant(idx);
            obs_order.push_back(idx);
            if (idx < 0) break;
            d = int'($urandom_range(dmax, dmin));
            tick();
            if (myturn != '0) obs_extra++;
            repeat (d - 1) begin
                drive_noise(idx);
                tick();
            end
            drive_noise(idx);
            passfwd[idx] = (script[k] != 1);
            passbak[idx] = (script[k] != 0);
            tick();
            passfwd = '0;
            passbak = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (myturn !== '0 || cur_idx !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            failed !== 1'b0 || proto_err !== 1'b0 || backtracks !== '0) begin
            errors++;
            $display("FAIL reset_state: got myturn=%b idx=%0d busy=%b done=%b failed=%b perr=%b bt=%0d, expected all zero",
                     myturn, cur_idx, busy, done, failed, proto_err, backtracks);
        end
    endtask

    task automatic test_forward();
        do_reset();
        do_start();
        script = '{0, 0, 0, 0};
        model_run();
        run_script(3, 3);
        checks++;
        if (order_diff() != -1) begin
            errors++;
            $display("FAIL fwd_order: got %0d grants (diff at %0d), expected %0d", obs_order.size(), order_diff(), exp_order.size());
        end
        checks++;
        if (obs_extra != 0 || obs_late != 0) begin
            errors++;
            $display("FAIL fwd_grant_timing: got extra=%0d late=%0d, expected 0 and 0", obs_extra, obs_late);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || failed !== 1'b0 || int'(cur_idx) != 3) begin
            errors++;
            $display("FAIL fwd_done: got done=%b busy=%b failed=%b idx=%0d, expected 1 0 0 3", done, busy, failed, cur_idx);
        end
        checks++;
        if (int'(backtracks) != exp_bt) begin
            errors++;
            $display("FAIL fwd_backtracks: got %0d expected %0d", backtracks, exp_bt);
        end
    endtask

    task automatic test_backtrack();
        do_reset();
        do_start();
        script = '{0, 0, 1, 0, 0, 0};
        model_run();
        run_script(3, 3);
        checks++;
        if (order_diff() != -1) begin
            errors++;
            $display("FAIL bak_order: got %0d grants (diff at %0d), expected %0d", obs_order.size(), order_diff(), exp_order.size());
        end
        checks++;
        if (int'(backtracks) != exp_bt || done !== 1'b1) begin
            errors++;
            $display("FAIL bak_result: got bt=%0d done=%b, expected bt=%0d done=1", backtracks, done, exp_bt);
        end
    endtask

    task automatic test_fail();
        int seen;
        do_reset();
        do_start();
        script = '{1};
        model_run();
        run_script(3, 3);
        checks++;
        if (failed !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || int'(backtracks) != exp_bt) begin
            errors++;
            $display("FAIL fail_state: got failed=%b done=%b busy=%b bt=%0d, expected 1 0 0 %0d",
                     failed, done, busy, backtracks, exp_bt);
        end
        do_start();
        seen = 0;
        repeat (6) begin
            if (myturn != '0 || busy !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || failed !== 1'b1) begin
            errors++;
            $display("FAIL fail_start_ignored: got %0d active cycles failed=%b, expected 0 and 1", seen, failed);
        end
    endtask

    task automatic test_ignore_other();
        int idx, seen;
        do_reset();
        do_start();
        script = '{0};
        run_script(3, 3);
        wait_grant(idx);
        tick();
        passfwd[3] = 1'b1;
        passbak[0] = 1'b1;
        tick();
        passfwd = '0;
        passbak = '0;
        seen = 0;
        repeat (3) begin
            if (myturn != '0) seen++;
            tick();
        end
        checks++;
        if (idx != 1 || int'(cur_idx) != 1 || busy !== 1'b1 || seen != 0) begin
            errors++;
            $display("FAIL ignore_others: got grant=%0d idx=%0d busy=%b stray=%0d, expected 1 1 1 0", idx, cur_idx, busy, seen);
        end
        passfwd[1] = 1'b1;
        tick();
        passfwd = '0;
        checks++;
        if (myturn !== 4'b0100) begin
            errors++;
            $display("FAIL ignore_then_fwd: got myturn=%b expected 0100", myturn);
        end
    endtask

    task automatic test_hold_proto();
        int seen;
        do_reset();
        hold = 1'b1;
        do_start();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (myturn != '0 || busy !== 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL hold_stall: got %0d bad cycles, expected 0", seen);
        end
        hold = 1'b0;
        #1;
        checks++;
        if (myturn !== 4'b0001) begin
            errors++;
            $display("FAIL hold_release: got myturn=%b expected 0001", myturn);
        end
        tick();
        checks++;
        if (myturn !== '0) begin
            errors++;
            $display("FAIL hold_single_pulse: got myturn=%b expected 0000", myturn);
        end
        passfwd[0] = 1'b1;
        tick();
        passfwd = '0;
        checks++;
        if (myturn !== 4'b0010) begin
            errors++;
            $display("FAIL hold_next_grant: got myturn=%b expected 0010", myturn);
        end
        tick();
        passfwd[1] = 1'b1;
        passbak[1] = 1'b1;
        tick();
        passfwd = '0;
        passbak = '0;
        checks++;
        if (proto_err !== 1'b1 || cur_idx !== 2'd0 || myturn !== 4'b0001 || backtracks !== 2'd1) begin
            errors++;
            $display("FAIL proto_both: got perr=%b idx=%0d myturn=%b bt=%0d, expected 1 0 0001 1",
                     proto_err, cur_idx, myturn, backtracks);
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        do_reset();
        do_start();
        script = '{0, 2, 0, 0};
        run_script(3, 3);
        wait_grant(idx);
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (idx != 2 || myturn !== '0 || cur_idx !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            failed !== 1'b0 || proto_err !== 1'b0 || backtracks !== '0) begin
            errors++;
            $display("FAIL reset_mid: got grant=%0d myturn=%b idx=%0d busy=%b done=%b failed=%b perr=%b bt=%0d, expected 2 then all zero",
                     idx, myturn, cur_idx, busy, done, failed, proto_err, backtracks);
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        do_start();
        script.delete();
        repeat (5) begin
            script.push_back(0);
            script.push_back(1);
        end
        repeat (4) script.push_back(0);
        model_run();
        run_script(1, 3);
        checks++;
        if (order_diff() != -1) begin
            errors++;
            $display("FAIL sat_order: got %0d grants (diff at %0d), expected %0d", obs_order.size(), order_diff(), exp_order.size());
        end
        checks++;
        if (backtracks !== 2'd3 || int'(backtracks) != exp_bt || done !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: got bt=%0d done=%b, expected 3 and 1", backtracks, done);
        end
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 15; it++) begin
            do_reset();
            noise_en = 1'($urandom_range(1, 0));
            hold_en  = 1'($urandom_range(1, 0));
            script.delete();
            for (int k = 0; k < 30; k++) begin
                r = int'($urandom_range(9, 0));
                script.push_back(r < 7 ? 0 : (r < 9 ? 1 : 2));
            end
            model_run();
            while (script.size() > exp_order.size()) void'(script.pop_back());
            do_start();
            run_script(1, 4);
            checks++;
            if (order_diff() != -1 || obs_extra != 0) begin
                errors++;
                $display("FAIL rand_order it=%0d: got %0d grants (diff at %0d, extra %0d), expected %0d",
                         it, obs_order.size(), order_diff(), obs_extra, exp_order.size());
            end
            checks++;
            if (int'(done) != exp_done || int'(failed) != exp_failed ||
                int'(busy) != ((exp_done != 0 || exp_failed != 0) ? 0 : 1)) begin
                errors++;
                $display("FAIL rand_status it=%0d: got done=%b failed=%b busy=%b, expected done=%0d failed=%0d",
                         it, done, failed, busy, exp_done, exp_failed);
            end
            checks++;
            if (int'(backtracks) != exp_bt || int'(proto_err) != exp_proto || int'(cur_idx) != exp_idx) begin
                errors++;
                $display("FAIL rand_counters it=%0d: got bt=%0d perr=%b idx=%0d, expected %0d %0d %0d",
                         it, backtracks, proto_err, cur_idx, exp_bt, exp_proto, exp_idx);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hold = 1'b0; passfwd = '0; passbak = '0;
        noise_en = 1'b0; hold_en = 1'b0;
        test_reset();
        test_forward();
        test_backtrack();
        test_fail();
        test_ignore_other();
        test_hold_proto();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Traversal controller for the brute-force grid solver. Hands control (myturn) to exactly one tile at a time, in index order.
- Advances to the next tile on that tile's passfwd. Retreats to the previous tile on passbak.
- Reports solved/unsolvable and counts backtracks.
- Sits between the top-level start/status interface and the array of NUM_TILES tile instances.

Parameters:
- NUM_TILES, 81, number of tiles in the grid (GRID_LEN squared); tile 0 is solved first.
- IDX_W, $clog2(NUM_TILES), width of the tile index.
- BTCNT_W, 16, width of the backtrack counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse. Begins traversal at tile 0; sampled only in IDLE.
- hold  in  1  when high, the sequencer withholds the next grant (stalls in GRANT).
- passfwd  in  NUM_TILES  per-tile "found a value" pulses.
- passbak  in  NUM_TILES  per-tile "exhausted, backtrack" pulses.
- myturn  out  NUM_TILES  one-hot grant pulse to the current tile; all-zero otherwise.
- cur_idx  out  IDX_W  index of the tile currently owning control.
- busy  out  1  high in GRANT or WAIT.
- done  out  1  sticky; grid solved.
- failed  out  1  sticky; backtracked past tile 0, no solution.
- proto_err  out  1  sticky; current tile asserted passfwd and passbak in the same cycle.
- backtracks  out  BTCNT_W  count of accepted passbak events, saturating.

Behaviour:
- Reset: state=IDLE, cur_idx=0, myturn=0, busy=0, done=0, failed=0, proto_err=0, backtracks=0. Reset mid-traversal aborts immediately; the tiles are reset by the same signal.
- States (one-hot encoded): IDLE, GRANT, WAIT, DONE, FAIL.
- IDLE:
  - start=1 -> GRANT with cur_idx=0, backtracks=0.
  - Otherwise stay in IDLE.
- GRANT:
  - hold=0: myturn[cur_idx]=1 for exactly this one cycle, then -> WAIT.
  - hold=1: myturn=0 and stay in GRANT.
  - myturn is registered-state decoded (Moore); never asserted outside GRANT.
- WAIT:
  - Only passfwd[cur_idx] and passbak[cur_idx] are examined. Pulses from any other tile are ignored.
  - Both current-tile pulses high in the same cycle: set proto_err and treat the event as passbak.
  - passfwd, cur_idx < NUM_TILES-1 -> cur_idx+1, go to GRANT.
  - passfwd, cur_idx == NUM_TILES-1 -> go to DONE; cur_idx holds.
  - passbak, cur_idx > 0 -> cur_idx-1, backtracks+1 (saturates at all-ones), go to GRANT.
  - passbak, cur_idx == 0 -> go to FAIL, backtracks+1.
  - Neither pulse -> stay in WAIT indefinitely; there is no timeout.
- DONE / FAIL:
  - Terminal. done (or failed) is held high, busy=0, and start is ignored.
  - Exit only via reset.
- Latency:
  - Tile pass pulse at cycle t -> sequencer state GRANT at t+1 -> myturn of the new tile high at t+1 (when hold=0).
  - The tile has already returned to WAITING at t+1, so the grant is never missed.
- cur_idx never wraps: no increment at the last tile, no decrement at tile 0.
- Only one tile is ever granted, so the shared row-bias request lines (OR-combined per row) are driven by at most one tile. This block therefore performs no separate arbitration.

Test Plan:
- NUM_TILES=4. After reset, start pulse; each tile returns passfwd 3 cycles after its grant -> myturn sequence 0001, 0010, 0100, 1000 (one cycle each); done=1 one cycle after tile 3's passfwd; backtracks=0.
- NUM_TILES=4. Tile 2 returns passbak once, then passfwd on its retry -> grant order 0,1,2,1,2,3; backtracks=1; done=1.
- NUM_TILES=4. Tile 0 returns passbak on its first grant -> failed=1, done=0, busy=0, backtracks=1; a later start pulse is ignored, myturn stays 0.
- While in WAIT on tile 1, pulse passfwd[3] and passbak[0] -> no state change and cur_idx=1; then passfwd[1] -> myturn=0100 on the next cycle.
- hold=1 for 5 cycles at a grant -> myturn=0 throughout the hold; a single one-cycle myturn after hold drops. Separately: passfwd[1] and passbak[1] together -> proto_err=1 and cur_idx goes 1->0.
- Reset asserted in WAIT on tile 2 -> next cycle state IDLE, cur_idx=0, all outputs at reset values. BTCNT_W=2 with 5 backtracks -> backtracks=3 (saturated).
